// File: rtl/add_share_arb.sv
// add_share_arb: round-robin arbiter time-sharing a single combinational adder among 4 requesters.
// Latency: gnt cycle -> CALC -> HOLD, so out_valid rises 2 cycles after the grant; one result per 3 cycles max.
// Backpressure: result is held in HOLD until out_ready; new requests wait (gnt=0) and are never lost.
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   req[3:0]            level requests, held until granted
//   a_bus, b_bus        packed operands, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   gnt[3:0]            one-hot grant, only in the capture cycle
//   out, out_id         registered sum and owning requester index
//   out_valid/out_ready result handshake
//   busy                high whenever the FSM is not IDLE

module add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  // Carry out is discarded: result is modulo 2^W.
  assign sum = a + b;
endmodule

module add_share_arb #(
  parameter int DATAWIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [3:0]             req,
  input  logic [4*DATAWIDTH-1:0] a_bus,
  input  logic [4*DATAWIDTH-1:0] b_bus,
  output logic [3:0]             gnt,
  output logic [DATAWIDTH-1:0]   out,
  output logic [1:0]             out_id,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [1:0]           p;
  logic [DATAWIDTH-1:0] op_a, op_b;
  logic [1:0]           op_id;
  logic [DATAWIDTH-1:0] sum;

  logic [DATAWIDTH-1:0] a_arr [4];
  logic [DATAWIDTH-1:0] b_arr [4];
  logic                 win_found;
  logic [1:0]           win_idx;
  logic [1:0]           cand;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = a_bus[i*DATAWIDTH +: DATAWIDTH];
      b_arr[i] = b_bus[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Round-robin search starting at p; the 2-bit add wraps naturally mod 4.
  always_comb begin
    win_found = 1'b0;
    win_idx   = p;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = p + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // The only adder in the block; it only ever sees the latched operands.
  add #(.W(DATAWIDTH)) u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  always_comb begin
    state_nxt = state;
    gnt       = 4'b0000;
    case (state)
      IDLE: begin
        if (win_found) begin
          // Grant is suppressed during reset so nothing appears to be captured.
          if (!Rst) gnt = 4'b0001 << win_idx;
          state_nxt = CALC;
        end
      end
      CALC:    state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE) && !Rst;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      p         <= 2'd0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= 2'd0;
      out       <= '0;
      out_id    <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (win_found) begin
            op_a  <= a_arr[win_idx];
            op_b  <= b_arr[win_idx];
            op_id <= win_idx;
            p     <= win_idx + 2'd1;
          end
        end
        CALC: begin
          out       <= sum;
          out_id    <= op_id;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_share_arb.sv
module tb_add_share_arb;

  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [3:0]    req;
  logic [4*DW-1:0] a_bus, b_bus;
  logic [3:0]    gnt;
  logic [DW-1:0] out;
  logic [1:0]    out_id;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  add_share_arb #(.DATAWIDTH(DW)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .gnt       (gnt),
    .out       (out),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] sum;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] tb_a [4];
  logic [DW-1:0] tb_b [4];
  logic [1:0]    p_model;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [DW-1:0] av, input logic [DW-1:0] bv);
    a_bus[i*DW +: DW] = av;
    b_bus[i*DW +: DW] = bv;
    tb_a[i] = av;
    tb_b[i] = bv;
  endtask

  // Reference arbiter: first set request searching p, p+1, p+2, p+3 (mod 4).
  function automatic int rr_pick(input logic [3:0] r, input logic [1:0] p);
    for (int k = 0; k < 4; k++) begin
      if (r[(int'(p) + k) % 4]) return (int'(p) + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int w);
    return (w < 0) ? 4'b0000 : 4'(1 << w);
  endfunction

  // Record the expected result for a grant to requester i and advance the model pointer.
  task automatic push_exp(input int i);
    exp_t e;
    logic [DW-1:0] s;
    s = tb_a[i] + tb_b[i];
    e.id  = 2'(i);
    e.sum = s;
    exp_q.push_back(e);
    p_model = 2'(i + 1);
  endtask

  // An empty queue yields X so the following comparison is forced to miss.
  task automatic pop_exp(output exp_t e);
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    p_model = 2'd0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; req = 4'b1111; out_ready = 1'b1; a_bus = '0; b_bus = '0;
    step(); step();
    vectors++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_gnt_busy: gnt=%b busy=%b required gnt=0000 busy=0", gnt, busy);
    end
    vectors++;
    if (out_valid !== 1'b0 || out !== 8'h00 || out_id !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_out: out_valid=%b out=%h out_id=%0d required 0/00/0", out_valid, out, out_id);
    end
    Rst = 1'b0; req = 4'b0000; p_model = 2'd0;
  endtask

  task automatic test_single();
    exp_t e;
    set_ops(0, 8'h12, 8'h34);
    req = 4'b0001;
    #1;
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++; $display("FAIL single_gnt: gnt=%b required 0001", gnt);
    end
    push_exp(0);
    step(); req = 4'b0000;
    vectors++;
    if (gnt !== 4'b0000 || busy !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_calc: gnt=%b busy=%b out_valid=%b required 0000/1/0", gnt, busy, out_valid);
    end
    step();
    pop_exp(e);
    vectors++;
    if (out_valid !== 1'b1 || out !== e.sum || out_id !== e.id || out !== 8'h46) begin
      miscompares++;
      $display("FAIL single_out: valid=%b out=%h id=%0d required 1/%h/%0d", out_valid, out, out_id, e.sum, e.id);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out !== 8'h46) begin
      miscompares++;
      $display("FAIL single_after: valid=%b busy=%b out=%h required 0/0/46", out_valid, busy, out);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    int w;
    set_ops(2, 8'hFF, 8'h02);
    req = 4'b0100;
    #1;
    w = rr_pick(req, p_model);
    vectors++;
    if (gnt !== onehot(w)) begin
      miscompares++; $display("FAIL wrap_gnt: gnt=%b required %b", gnt, onehot(w));
    end
    push_exp(w);
    step(); req = 4'b0000;
    step();
    pop_exp(e);
    vectors++;
    if (out_valid !== 1'b1 || out !== e.sum || out_id !== e.id) begin
      miscompares++;
      $display("FAIL wrap_out: valid=%b out=%h id=%0d required 1/%h/%0d", out_valid, out, out_id, e.sum, e.id);
    end
    step();
  endtask

  task automatic test_fairness();
    exp_t e;
    int w;
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1;
      w = rr_pick(req, p_model);
      vectors++;
      if (gnt !== onehot(w)) begin
        miscompares++; $display("FAIL fair_gnt%0d: gnt=%b required %b", n, gnt, onehot(w));
      end
      push_exp(w);
      step();
      vectors++;
      if (gnt !== 4'b0000) begin
        miscompares++; $display("FAIL fair_calc_gnt%0d: gnt=%b required 0000", n, gnt);
      end
      step();
      pop_exp(e);
      vectors++;
      if (out_valid !== 1'b1 || out !== e.sum || out_id !== e.id) begin
        miscompares++;
        $display("FAIL fair_out%0d: valid=%b out=%h id=%0d required 1/%h/%0d", n, out_valid, out, out_id, e.sum, e.id);
      end
      step();
    end
    req = 4'b0000;
  endtask

  task automatic test_backpressure();
    exp_t e;
    int w;
    out_ready = 1'b0;
    set_ops(1, 8'h70, 8'h25);
    set_ops(0, 8'h03, 8'h04);
    req = 4'b0010;
    #1;
    w = rr_pick(req, p_model);
    vectors++;
    if (gnt !== onehot(w)) begin
      miscompares++; $display("FAIL bp_gnt: gnt=%b required %b", gnt, onehot(w));
    end
    push_exp(w);
    step();
    // Disturb the in-flight requester's operands and raise a new request mid-operation.
    req = 4'b0001;
    a_bus[1*DW +: DW] = 8'hAA;
    step();
    pop_exp(e);
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || out !== e.sum || out_id !== e.id || gnt !== 4'b0000 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold%0d: valid=%b out=%h id=%0d gnt=%b busy=%b required 1/%h/%0d/0000/1",
                 c, out_valid, out, out_id, gnt, busy, e.sum, e.id);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    w = rr_pick(req, p_model);
    vectors++;
    if (out_valid !== 1'b0 || gnt !== onehot(w)) begin
      miscompares++;
      $display("FAIL bp_release: valid=%b gnt=%b required 0/%b", out_valid, gnt, onehot(w));
    end
    push_exp(w);
    step(); req = 4'b0000;
    step();
    pop_exp(e);
    vectors++;
    if (out_valid !== 1'b1 || out !== e.sum || out_id !== e.id) begin
      miscompares++;
      $display("FAIL bp_next_out: valid=%b out=%h id=%0d required 1/%h/%0d", out_valid, out, out_id, e.sum, e.id);
    end
    step();
  endtask

  task automatic test_ptr_skip();
    exp_t e;
    int w;
    do_reset();
    set_ops(0, 8'h11, 8'h22);
    set_ops(1, 8'h80, 8'h90);
    for (int n = 0; n < 2; n++) begin
      req = (n == 0) ? 4'b0010 : 4'b0011;
      #1;
      w = rr_pick(req, p_model);
      vectors++;
      if (gnt !== onehot(w) || (n == 1 && gnt !== 4'b0001)) begin
        miscompares++; $display("FAIL skip_gnt%0d: gnt=%b required %b", n, gnt, onehot(w));
      end
      push_exp(w);
      step(); req = 4'b0000;
      step();
      pop_exp(e);
      vectors++;
      if (out_valid !== 1'b1 || out !== e.sum || out_id !== e.id) begin
        miscompares++;
        $display("FAIL skip_out%0d: valid=%b out=%h id=%0d required 1/%h/%0d", n, out_valid, out, out_id, e.sum, e.id);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int w;
    set_ops(1, 8'h05, 8'h06);
    set_ops(3, 8'h40, 8'h01);
    set_ops(0, 8'h09, 8'h09);
    req = 4'b0010;
    step();
    req = 4'b0000;
    Rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      miscompares++; $display("FAIL rstmid_busy: busy=%b gnt=%b required 0/0000", busy, gnt);
    end
    step();
    Rst = 1'b0; p_model = 2'd0;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (out_valid !== 1'b0 || out !== 8'h00 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_abort%0d: valid=%b out=%h busy=%b required 0/00/0", c, out_valid, out, busy);
      end
      step();
    end
    for (int n = 0; n < 2; n++) begin
      req = (n == 0) ? 4'b1000 : 4'b1001;
      #1;
      w = rr_pick(req, p_model);
      vectors++;
      if (gnt !== onehot(w)) begin
        miscompares++; $display("FAIL rstmid_gnt%0d: gnt=%b required %b", n, gnt, onehot(w));
      end
      push_exp(w);
      step(); req = 4'b0000;
      step();
      pop_exp(e);
      vectors++;
      if (out_valid !== 1'b1 || out !== e.sum || out_id !== e.id) begin
        miscompares++;
        $display("FAIL rstmid_out%0d: valid=%b out=%h id=%0d required 1/%h/%0d", n, out_valid, out, out_id, e.sum, e.id);
      end
      step();
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_backpressure();
    test_ptr_skip();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
